pattern_scheduler: RTL and testbench
====================================

PATTERN_SCHEDULER -- requirements
Module: pattern_scheduler

Interface
REQ-001 SHALL have parameter TS_W, default 10, meaning the timestamp width; memory depth is 2**TS_W slots per channel.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the pattern width per channel.
REQ-003 SHALL have parameter CH, default 2, meaning the channel count (1..16).
REQ-004 SHALL have port CLOCK50M  in  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET_N  in  1  meaning an asynchronous, active-low reset.
REQ-006 SHALL have port write  in  1  meaning a register write strobe, sampled each cycle.
REQ-007 SHALL have port address  in  2  meaning the register select: 0 = PATTERN, 1 = CTRL, 2 = PERIOD, 3 = CLEAR.
REQ-008 SHALL have port writedata  in  32  meaning PATTERN layout {ch[31:28], ts[TS_W+DATA_W-1:DATA_W], data[DATA_W-1:0]}; CTRL bit0 = run, bit1 = loop; PERIOD bits[TS_W-1:0].
REQ-009 SHALL have port tick  in  1  meaning a time-base advance pulse.
REQ-010 SHALL have port pattern_out  out  CH*DATA_W  meaning channel c occupies bits [c*DATA_W +: DATA_W].
REQ-011 SHALL have port timestamp  out  TS_W  meaning the current playback position.
REQ-012 SHALL have port busy  out  1  meaning a clear sweep is in progress.
REQ-013 SHALL have port wrap  out  1  meaning a one-cycle pulse on loop wrap-around.

Function
REQ-014 A PATTERN write SHALL store data and set the valid bit at slot ts of bank ch; a write with ch >= CH SHALL be ignored.
REQ-015 A CTRL write SHALL load run and loop; a PERIOD write SHALL load period; a CLEAR write SHALL start a sweep.
REQ-016 On tick with run=1 and timestamp != period, timestamp SHALL increment by 1.
REQ-017 On tick with run=1 and timestamp == period: with loop=1, timestamp SHALL become 0 and wrap SHALL pulse for one cycle; with loop=0, run SHALL clear and timestamp SHALL hold.
REQ-018 A tick with run=0 SHALL be ignored; if period < timestamp after a PERIOD write, the next tick SHALL take the timestamp == period path (wrap or stop).
REQ-019 pattern_out SHALL be registered, with 1-cycle latency: it reflects slot timestamp of each bank one cycle after timestamp changes.
REQ-020 A write to the slot being read in the same cycle SHALL return the old data (read-before-write).
REQ-021 The clear sweep SHALL walk slots 0..2**TS_W-1, one per cycle, zeroing data and valid in all banks; busy SHALL be high for exactly 2**TS_W cycles.
REQ-022 While busy, all writes SHALL be ignored and playback SHALL continue, with invalid slots handled per REQ-026.
REQ-023 A CTRL write coinciding with a wrap tick SHALL take priority for run and loop; the timestamp update SHALL still occur.

Reset
REQ-024 Reset assertion SHALL immediately set timestamp=0, run=0, loop=0, period=all ones, pattern_out=0, wrap=0, busy=1, sweep pointer=0.
REQ-025 After reset release, an automatic clear sweep SHALL run; memory is not cleared by reset itself, and reset mid-sweep SHALL restart the sweep at 0.

Configuration
REQ-026 With PATTERN_SCHED_HOLD_EN defined, an invalid slot SHALL leave that channel's pattern_out unchanged; without it, that channel SHALL output 0.

Structure
REQ-027 Package pattern_pkg SHALL hold default TS_W/DATA_W/CH, the address codes, and the CTRL bit positions.
REQ-028 Sub-module pattern_bank SHALL implement one channel's memory with its valid bit, registered read, and a sweep-clear port; it SHALL be instantiated CH times in a generate loop.

Verification
REQ-029 Release reset, hold -> busy high for exactly 1024 cycles, then low; pattern_out=0.
REQ-030 Write PATTERN ch=1 ts=5 data=0xA5; CTRL run=1; pulse tick 5 times -> timestamp=5, channel-1 byte=0xA5 one cycle later, channel 0 per REQ-026.
REQ-031 PERIOD=3, loop=1, continuous ticks -> timestamp sequence 0,1,2,3,0 with wrap pulsed once, at the 3->0 transition.
REQ-032 PERIOD=3, loop=0 -> timestamp stops at 3 and run reads back as 0; further ticks produce no change.
REQ-033 CLEAR write then PATTERN write during busy -> write dropped; the slot reads invalid after the sweep.
REQ-034 Assert RESET_N mid-sweep at pointer 500 -> outputs reset instantly; sweep restarts and busy lasts a full 1024 cycles.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared defaults, register address codes and CTRL bit positions for the pattern scheduler.
package pattern_pkg;
    localparam int DEF_TS_W   = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CH     = 2;

    typedef enum logic [1:0] {
        ADDR_PATTERN = 2'd0,
        ADDR_CTRL    = 2'd1,
        ADDR_PERIOD  = 2'd2,
        ADDR_CLEAR   = 2'd3
    } addr_e;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_LOOP_BIT = 1;
    localparam int CH_LSB        = 28;
endpackage

// File: rtl/pattern_bank.sv
// One channel's pattern memory plus valid bits; registered read (1 cycle), read-before-write.
// The sweep-clear port overrides the write port; no backpressure.
module pattern_bank
    import pattern_pkg::*;
#(
    parameter int TS_W   = DEF_TS_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [TS_W-1:0]   i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_clr_en,
    input  logic [TS_W-1:0]   i_clr_addr,
    input  logic [TS_W-1:0]   i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [2**TS_W];
    logic              r_vld [2**TS_W];
    logic [DATA_W-1:0] r_q;

    // Storage is deliberately not reset; the post-reset sweep clears it.
    always_ff @(posedge i_clk) begin
        if (i_clr_en) begin
            r_mem[i_clr_addr] <= '0;
            r_vld[i_clr_addr] <= 1'b0;
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
            r_vld[i_wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (r_vld[i_rd_addr]) begin
            r_q <= r_mem[i_rd_addr];
        end else begin
`ifdef PATTERN_SCHED_HOLD_EN
            r_q <= r_q;
`else
            r_q <= '0;
`endif
        end
    end

    assign o_rd_data = r_q;
endmodule

// File: rtl/pattern_scheduler.sv
// Timestamped multi-channel pattern player; pattern_out lags timestamp by 1 cycle, writes dropped while busy.
// Define PATTERN_SCHED_HOLD_EN to hold a channel's output on invalid slots instead of driving 0.
module pattern_scheduler
    import pattern_pkg::*;
#(
    parameter int TS_W   = DEF_TS_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH     = DEF_CH
) (
    input  logic                 CLOCK50M,
    input  logic                 RESET_N,
    input  logic                 write,
    input  logic [1:0]           address,
    input  logic [31:0]          writedata,
    input  logic                 tick,
    output logic [CH*DATA_W-1:0] pattern_out,
    output logic [TS_W-1:0]      timestamp,
    output logic                 busy,
    output logic                 wrap
);
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_period;
    logic [TS_W-1:0] r_ptr;
    logic            r_run;
    logic            r_loop;
    logic            r_wrap;
    logic            r_busy;

    logic              w_wr_ok;
    logic              w_pat_wr;
    logic [3:0]        w_wr_ch;
    logic [TS_W-1:0]   w_wr_ts;
    logic [DATA_W-1:0] w_wr_data;

    assign w_wr_ok   = write && !r_busy;
    assign w_pat_wr  = w_wr_ok && (address == ADDR_PATTERN);
    assign w_wr_ch   = writedata[CH_LSB +: 4];
    assign w_wr_ts   = writedata[DATA_W +: TS_W];
    assign w_wr_data = writedata[DATA_W-1:0];

    always_ff @(posedge CLOCK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ts     <= '0;
            r_run    <= 1'b0;
            r_loop   <= 1'b0;
            r_period <= '1;
            r_wrap   <= 1'b0;
            r_busy   <= 1'b1;
            r_ptr    <= '0;
        end else begin
            r_wrap <= 1'b0;
            // ">=" so a period shrunk below the current position still wraps or stops.
            if (tick && r_run) begin
                if (r_ts >= r_period) begin
                    if (r_loop) begin
                        r_ts   <= '0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_run <= 1'b0;
                    end
                end else begin
                    r_ts <= r_ts + 1'b1;
                end
            end
            // Placed after the tick logic so a coincident CTRL write wins for run/loop.
            if (w_wr_ok) begin
                case (address)
                    ADDR_CTRL: begin
                        r_run  <= writedata[CTRL_RUN_BIT];
                        r_loop <= writedata[CTRL_LOOP_BIT];
                    end
                    ADDR_PERIOD: r_period <= writedata[TS_W-1:0];
                    default: ;
                endcase
            end
            if (r_busy) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_ptr == '1) begin
                    r_busy <= 1'b0;
                end
            end else if (w_wr_ok && (address == ADDR_CLEAR)) begin
                r_busy <= 1'b1;
                r_ptr  <= '0;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_bank
        logic w_sel;
        assign w_sel = w_pat_wr && (w_wr_ch == 4'(c));

        pattern_bank #(
            .TS_W   (TS_W),
            .DATA_W (DATA_W)
        ) u_bank (
            .i_clk      (CLOCK50M),
            .i_rst_n    (RESET_N),
            .i_wr_en    (w_sel),
            .i_wr_addr  (w_wr_ts),
            .i_wr_data  (w_wr_data),
            .i_clr_en   (r_busy),
            .i_clr_addr (r_ptr),
            .i_rd_addr  (r_ts),
            .o_rd_data  (pattern_out[c*DATA_W +: DATA_W])
        );
    end

    assign timestamp = r_ts;
    assign busy      = r_busy;
    assign wrap      = r_wrap;
endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed bench for pattern_scheduler at default parameters (TS_W=10, DATA_W=8, CH=2).
module tb_pattern_scheduler;
    logic        CLOCK50M  = 1'b0;
    logic        RESET_N   = 1'b0;
    logic        write     = 1'b0;
    logic [1:0]  address   = 2'd0;
    logic [31:0] writedata = 32'd0;
    logic        tick      = 1'b0;
    logic [15:0] pattern_out;
    logic [9:0]  timestamp;
    logic        busy;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  adr;
        logic [31:0] wd;
        logic        tk;
        logic [9:0]  ts;
        logic        wp;
        logic [15:0] po;
    } vec_t;

    vec_t vecs[$];

    always #10 CLOCK50M = ~CLOCK50M;

    pattern_scheduler dut (
        .CLOCK50M    (CLOCK50M),
        .RESET_N     (RESET_N),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .tick        (tick),
        .pattern_out (pattern_out),
        .timestamp   (timestamp),
        .busy        (busy),
        .wrap        (wrap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [1:0] adr, input logic [31:0] wd,
                       input logic tk, input logic [9:0] ts, input logic wp, input logic [15:0] po);
        vec_t v;
        v.wr = wr; v.adr = adr; v.wd = wd; v.tk = tk;
        v.ts = ts; v.wp = wp; v.po = po;
        vecs.push_back(v);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge CLOCK50M);
        end
    endtask

    initial begin
        int n;
        // {write, address, writedata, tick} -> {timestamp, wrap, pattern_out} one edge later
        add(1, 2'd0, 32'h1000_05A5, 0, 10'd0, 0, 16'h0000); // ch1 ts5 A5
        add(1, 2'd0, 32'h0000_023C, 0, 10'd0, 0, 16'h0000); // ch0 ts2 3C
        add(1, 2'd0, 32'h2000_00FF, 0, 10'd0, 0, 16'h0000); // ch2 ignored
        add(1, 2'd1, 32'h0000_0001, 0, 10'd0, 0, 16'h0000); // run=1 loop=0
        add(0, 2'd0, 32'h0,         1, 10'd1, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         1, 10'd2, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         1, 10'd3, 0, 16'h003C);
        add(0, 2'd0, 32'h0,         1, 10'd4, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         1, 10'd5, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         0, 10'd5, 0, 16'hA500);
        add(1, 2'd2, 32'h0000_0003, 0, 10'd5, 0, 16'hA500); // period 3 < ts
        add(0, 2'd0, 32'h0,         1, 10'd5, 0, 16'hA500); // stop path
        add(0, 2'd0, 32'h0,         1, 10'd5, 0, 16'hA500); // run=0 ignored
        add(1, 2'd1, 32'h0000_0003, 0, 10'd5, 0, 16'hA500); // run=1 loop=1
        add(0, 2'd0, 32'h0,         1, 10'd0, 1, 16'hA500); // wrap from 5
        add(0, 2'd0, 32'h0,         1, 10'd1, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         1, 10'd2, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         1, 10'd3, 0, 16'h003C);
        add(0, 2'd0, 32'h0,         1, 10'd0, 1, 16'h0000); // 3 -> 0
        add(0, 2'd0, 32'h0,         1, 10'd1, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         1, 10'd2, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         1, 10'd3, 0, 16'h003C);
        add(1, 2'd1, 32'h0000_0000, 1, 10'd0, 1, 16'h0000); // CTRL on wrap tick
        add(0, 2'd0, 32'h0,         1, 10'd0, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         1, 10'd0, 0, 16'h0000);
        add(1, 2'd1, 32'h0000_0001, 0, 10'd0, 0, 16'h0000); // run=1 loop=0
        add(0, 2'd0, 32'h0,         1, 10'd1, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         1, 10'd2, 0, 16'h0000);
        add(0, 2'd0, 32'h0,         1, 10'd3, 0, 16'h003C);
        add(0, 2'd0, 32'h0,         1, 10'd3, 0, 16'h0000); // stops at 3
        add(0, 2'd0, 32'h0,         1, 10'd3, 0, 16'h0000);
        add(1, 2'd0, 32'h0000_0377, 0, 10'd3, 0, 16'h0000); // write slot being read
        add(0, 2'd0, 32'h0,         0, 10'd3, 0, 16'h0077);

        repeat (3) @(negedge CLOCK50M);
        chk("rst_ts",   32'(timestamp),   32'd0);
        chk("rst_po",   32'(pattern_out), 32'd0);
        chk("rst_wrap", 32'(wrap),        32'd0);
        chk("rst_busy", 32'(busy),        32'd1);

        RESET_N = 1'b1;
        count_busy(n);
        chk("por_busy_len", n, 1024);
        chk("por_po", 32'(pattern_out), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            write = vecs[i].wr; address = vecs[i].adr;
            writedata = vecs[i].wd; tick = vecs[i].tk;
            @(negedge CLOCK50M);
            chk($sformatf("v%0d_ts", i),   32'(timestamp),   32'(vecs[i].ts));
            chk($sformatf("v%0d_wrap", i), 32'(wrap),        32'(vecs[i].wp));
            chk($sformatf("v%0d_po", i),   32'(pattern_out), 32'(vecs[i].po));
        end
        write = 1'b0; tick = 1'b0;
        chk("run_cleared", 32'(dut.r_run), 32'd0);

        // CLEAR, then PATTERN and CTRL writes during busy must be dropped
        write = 1'b1; address = 2'd3; writedata = 32'd0;
        @(negedge CLOCK50M);
        chk("clr_busy", 32'(busy), 32'd1);
        address = 2'd0; writedata = 32'h1000_0399;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            if (n == 2) begin
                address = 2'd1; writedata = 32'h0000_0003;
            end else if (n == 3) begin
                write = 1'b0;
            end
            @(negedge CLOCK50M);
        end
        write = 1'b0;
        chk("clr_busy_len", n, 1024);
        tick = 1'b1;
        @(negedge CLOCK50M);
        tick = 1'b0;
        chk("clr_ctrl_dropped", 32'(timestamp),   32'd3);
        chk("clr_slot_invalid", 32'(pattern_out), 32'd0);

        // Reset mid-sweep at pointer 500
        write = 1'b1; address = 2'd3;
        @(negedge CLOCK50M);
        write = 1'b0;
        n = 0;
        while (dut.r_ptr != 10'd500 && n < 1100) begin
            n++;
            @(negedge CLOCK50M);
        end
        chk("ptr_reach", 32'(dut.r_ptr), 32'd500);
        #2 RESET_N = 1'b0;
        #1;
        chk("mid_rst_ts",     32'(timestamp),    32'd0);
        chk("mid_rst_busy",   32'(busy),         32'd1);
        chk("mid_rst_po",     32'(pattern_out),  32'd0);
        chk("mid_rst_wrap",   32'(wrap),         32'd0);
        chk("mid_rst_ptr",    32'(dut.r_ptr),    32'd0);
        chk("mid_rst_period", 32'(dut.r_period), 32'h3FF);
        @(negedge CLOCK50M);
        @(negedge CLOCK50M);
        RESET_N = 1'b1;
        count_busy(n);
        chk("mid_rst_busy_len", n, 1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
